// File: rtl/exu_ctrl_pkg.sv
// ============================================================================
// Module : exu_ctrl_pkg
// Brief  : Shared state encodings, stall counter width and sizing helper for
//          the EXU control slice.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package exu_ctrl_pkg;

  localparam logic [1:0] EXU_ST_IDLE  = 2'd0;
  localparam logic [1:0] EXU_ST_MC    = 2'd1;
  localparam logic [1:0] EXU_ST_VALID = 2'd2;

  localparam int STALL_CNT_W = 32;

  // Minimum width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/exu_mc_timer.sv
// ============================================================================
// Module : exu_mc_timer
// Brief  : Countdown for multi-cycle ops: load MC_CYCLES-1, decrement while
//          counting, done while the count reads zero.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module exu_mc_timer #(
  parameter int MC_CYCLES = 8,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_load,
  input  logic i_count,
  output logic o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(MC_CYCLES - 1);
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/exu_ctrl.sv
// ============================================================================
// Module : exu_ctrl
// Brief  : EX stage control FSM (IDLE/MC/VALID) with IDU/LSU handshakes.
//          Multi-cycle path enabled by macro EXU_MULDIV_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module exu_ctrl
  import exu_ctrl_pkg::*;
#(
  parameter int MC_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   idu_valid_i,
  input  logic                   mc_op_i,
  output logic                   exu_ready_o,
  output logic                   we_o,
  output logic                   alu_start_o,
  output logic                   exu_valid_o,
  input  logic                   lsu_ready_i,
  input  logic                   flush_i,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam int CNT_W = cnt_width(MC_CYCLES);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_exu_valid;
  logic       w_accept;
  logic       w_mc_accept;
  logic       w_mc_done;

  assign exu_ready_o = ~flush_i & ((r_state == EXU_ST_IDLE) |
                                   ((r_state == EXU_ST_VALID) & lsu_ready_i));
  assign w_accept    = idu_valid_i & exu_ready_o;
  assign we_o        = w_accept;

`ifdef EXU_MULDIV_EN
  logic                   r_alu_start;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign w_mc_accept = w_accept & mc_op_i;

  exu_mc_timer #(
    .MC_CYCLES (MC_CYCLES),
    .CNT_W     (CNT_W)
  ) u_mc_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (flush_i),
    .i_load  (w_mc_accept),
    .i_count (r_state == EXU_ST_MC),
    .o_done  (w_mc_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_start <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_alu_start <= w_mc_accept;
      if (r_state == EXU_ST_MC) begin
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

  // Start pulse is suppressed if the op is killed in its first MC cycle.
  assign alu_start_o = r_alu_start & ~flush_i;
  assign stall_cnt_o = r_stall_cnt;
`else
  logic w_unused;

  assign w_unused    = mc_op_i ^ CNT_W[0];
  assign w_mc_accept = 1'b0;
  assign w_mc_done   = 1'b1;
  assign alu_start_o = 1'b0;
  assign stall_cnt_o = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = EXU_ST_IDLE;
    end else begin
      case (r_state)
        EXU_ST_IDLE: begin
          if (w_accept) w_state_nxt = w_mc_accept ? EXU_ST_MC : EXU_ST_VALID;
        end
        EXU_ST_MC: begin
          if (w_mc_done) w_state_nxt = EXU_ST_VALID;
        end
        EXU_ST_VALID: begin
          if (lsu_ready_i) begin
            if (w_accept) w_state_nxt = w_mc_accept ? EXU_ST_MC : EXU_ST_VALID;
            else          w_state_nxt = EXU_ST_IDLE;
          end
        end
        default: w_state_nxt = EXU_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EXU_ST_IDLE;
      r_exu_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_exu_valid <= (w_state_nxt == EXU_ST_VALID);
    end
  end

  assign exu_valid_o = r_exu_valid;

endmodule

`default_nettype wire

// File: tb/tb_exu_ctrl.sv
// ============================================================================
// Module : tb_exu_ctrl
// Brief  : Self-checking bench for exu_ctrl; MC scenarios under EXU_MULDIV_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_exu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        idu_valid_i = 1'b0;
  logic        mc_op_i = 1'b0;
  logic        lsu_ready_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        exu_ready_o;
  logic        we_o;
  logic        alu_start_o;
  logic        exu_valid_o;
  logic [31:0] stall_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exu_ctrl #(.MC_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .idu_valid_i (idu_valid_i),
    .mc_op_i     (mc_op_i),
    .exu_ready_o (exu_ready_o),
    .we_o        (we_o),
    .alu_start_o (alu_start_o),
    .exu_valid_o (exu_valid_o),
    .lsu_ready_i (lsu_ready_i),
    .flush_i     (flush_i),
    .stall_cnt_o (stall_cnt_o)
  );

  typedef struct packed {
    logic idu;
    logic lsu;
    logic flush;
    logic exp_ready;
    logic exp_we;
    logic exp_valid;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic idu, input logic mc, input logic lsu, input logic fl);
    @(negedge clk);
    idu_valid_i = idu;
    mc_op_i     = mc;
    lsu_ready_i = lsu;
    flush_i     = fl;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idu_valid_i = 1'b1;
    mc_op_i     = 1'b0;
    lsu_ready_i = 1'b0;
    flush_i     = 1'b0;
    rst         = 1'b1;
    #1;
    chk("rst_ready", {31'd0, exu_ready_o}, 32'd1);
    chk("rst_valid", {31'd0, exu_valid_o}, 32'd0);
    chk("rst_start", {31'd0, alu_start_o}, 32'd0);
    chk("rst_stall", stall_cnt_o, 32'd0);
    #2;
    rst         = 1'b0;
    idu_valid_i = 1'b0;
  endtask

  initial begin
    // idu, lsu, flush -> ready, we, valid
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    #12;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].idu, 1'b0, vecs[i].lsu, vecs[i].flush);
      chk($sformatf("vec%0d_ready", i), {31'd0, exu_ready_o}, {31'd0, vecs[i].exp_ready});
      chk($sformatf("vec%0d_we", i),    {31'd0, we_o},        {31'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_valid", i), {31'd0, exu_valid_o}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_start", i), {31'd0, alu_start_o}, 32'd0);
    end

    // Asynchronous reset while VALID abandons the instruction.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst_pre_valid", {31'd0, exu_valid_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, exu_valid_o}, 32'd0);
    chk("arst_ready", {31'd0, exu_ready_o}, 32'd1);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst_post_valid", {31'd0, exu_valid_o}, 32'd0);
    chk("arst_post_ready", {31'd0, exu_ready_o}, 32'd1);

    // Four back-to-back single-cycle ops.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(k < 4, 1'b0, 1'b1, 1'b0);
      chk($sformatf("b2b%0d_we", k),    {31'd0, we_o},        {31'd0, (k < 4)});
      chk($sformatf("b2b%0d_valid", k), {31'd0, exu_valid_o}, {31'd0, (k >= 1 && k <= 4)});
    end

    // LSU backpressure for 5 cycles.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("bp%0d_valid", k), {31'd0, exu_valid_o}, 32'd1);
      chk($sformatf("bp%0d_we", k),    {31'd0, we_o},        32'd0);
      chk($sformatf("bp%0d_ready", k), {31'd0, exu_ready_o}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_release_ready", {31'd0, exu_ready_o}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_release_valid", {31'd0, exu_valid_o}, 32'd0);

`ifdef EXU_MULDIV_EN
    // Multi-cycle op, MC_CYCLES=8: start at cycle 1, valid at cycle 9.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("mc_acc_we", {31'd0, we_o}, 32'd1);
    chk("mc_acc_start", {31'd0, alu_start_o}, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("mc%0d_start", k), {31'd0, alu_start_o}, {31'd0, (k == 1)});
      chk($sformatf("mc%0d_valid", k), {31'd0, exu_valid_o}, {31'd0, (k >= 9)});
      chk($sformatf("mc%0d_ready", k), {31'd0, exu_ready_o}, 32'd0);
      if (k >= 9) chk($sformatf("mc%0d_stall", k), stall_cnt_o, 32'd8);
    end

    // Flush in MC cycle 3.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("fl%0d_start", k), {31'd0, alu_start_o}, {31'd0, (k == 1)});
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("fl3_we", {31'd0, we_o}, 32'd0);
    chk("fl3_start", {31'd0, alu_start_o}, 32'd0);
    chk("fl3_ready", {31'd0, exu_ready_o}, 32'd0);
    for (int k = 4; k <= 13; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("fl%0d_valid", k), {31'd0, exu_valid_o}, 32'd0);
      if (k == 4) chk("fl4_ready", {31'd0, exu_ready_o}, 32'd1);
    end
    chk("fl_stall", stall_cnt_o, 32'd3);
`else
    // Without mul/div support an mc_op accept is single-cycle.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("nomc_acc_we", {31'd0, we_o}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("nomc_valid", {31'd0, exu_valid_o}, 32'd1);
    chk("nomc_start", {31'd0, alu_start_o}, 32'd0);
    chk("nomc_stall", stall_cnt_o, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("nomc_hold_valid", {31'd0, exu_valid_o}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("nomc_done_valid", {31'd0, exu_valid_o}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exu_ctrl.md
EXU_CTRL -- requirements
Module: exu_ctrl

Interface
REQ-001 SHALL have parameter MC_CYCLES, default 8, giving busy cycles of a multi-cycle (mul/div) op; legal range 1..255.
REQ-002 SHALL have localparam CNT_W, equal to the minimum width holding MC_CYCLES-1, with a floor of 1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port idu_valid_i, input, 1 bit: IDU presents a decoded instruction.
REQ-006 SHALL have port mc_op_i, input, 1 bit: the presented instruction is multi-cycle; sampled only on accept.
REQ-007 SHALL have port exu_ready_o, output, 1 bit: EXU can accept this cycle.
REQ-008 SHALL have port we_o, output, 1 bit: write enable to the EX stage register.
REQ-009 SHALL have port alu_start_o, output, 1 bit: one-cycle start pulse to the multi-cycle unit.
REQ-010 SHALL have port exu_valid_o, output, 1 bit: EX result valid toward LSU.
REQ-011 SHALL have port lsu_ready_i, input, 1 bit: LSU accepts the EX result.
REQ-012 SHALL have port flush_i, input, 1 bit: kill the in-flight instruction.
REQ-013 SHALL have port stall_cnt_o, output, 32 bits: running count of cycles spent in state MC.

Function
REQ-014 SHALL implement FSM states IDLE, MC and VALID.
REQ-015 SHALL drive exu_ready_o = ~flush_i & ((state==IDLE) | (state==VALID & lsu_ready_i)), combinationally.
REQ-016 SHALL define accept as idu_valid_i & exu_ready_o, and SHALL drive we_o = accept, so the stage register loads only on accept.
REQ-017 On accept with mc_op_i=0, SHALL go to VALID next cycle; single-cycle latency is 1 cycle, accept to exu_valid_o.
REQ-018 On accept with mc_op_i=1, SHALL go to MC, load the counter with MC_CYCLES-1, and assert alu_start_o for exactly the first MC cycle.
REQ-019 In MC, SHALL decrement the counter each cycle and go to VALID in the cycle after the counter reads 0; multi-cycle latency is MC_CYCLES+1 cycles, accept to exu_valid_o.
REQ-020 SHALL drive exu_valid_o = (state==VALID) as a registered decode, glitch-free.
REQ-021 In VALID with lsu_ready_i=1: SHALL go to IDLE with no accept; with a simultaneous accept, SHALL go directly to MC or VALID, giving back-to-back throughput of one per cycle.
REQ-022 In VALID with lsu_ready_i=0, SHALL hold state; exu_valid_o stays 1 and the stage register is not rewritten.
REQ-023 flush_i SHALL have top priority: next state IDLE, counter cleared, no accept and no alu_start_o in the flush cycle; exu_valid_o is 0 the following cycle.
REQ-024 SHALL increment stall_cnt_o each cycle state==MC, wrapping modulo 2^32; flush SHALL NOT clear it.
REQ-025 lsu_ready_i SHALL be ignored outside VALID, and idu_valid_i ignored when exu_ready_o=0.

Reset
REQ-026 On rst=1, SHALL immediately set state IDLE, counter 0 and stall_cnt_o 0, and force exu_valid_o=0 and alu_start_o=0, independent of clk.
REQ-027 Reset asserted mid-MC or mid-VALID SHALL abandon the instruction; after rst deasserts, exu_ready_o=1 follows the combinational rule.

Configuration
REQ-028 Macro EXU_MULDIV_EN defined: the MC path, counter, alu_start_o and stall_cnt_o behave as specified.
REQ-029 Macro EXU_MULDIV_EN undefined: mc_op_i is ignored, every accept goes to VALID, alu_start_o is tied 0, stall_cnt_o is tied 0, and no counter logic is generated.

Structure
REQ-030 State encodings EXU_ST_IDLE/MC/VALID (2 bits) and the stall counter width SHALL live in the shared defines file.
REQ-031 The countdown SHALL be one sub-module, exu_mc_timer (load, count, done), instantiated only under EXU_MULDIV_EN.
REQ-032 exu_ctrl SHALL instantiate no datapath; it drives the existing EX stage register through we_o only.

Verification
REQ-033 SHALL cover: reset with idu_valid_i=1 -> exu_ready_o=1, exu_valid_o=0, stall_cnt_o=0.
REQ-034 SHALL cover: MC_CYCLES=8, accept with mc_op_i=1 at cycle 0 -> alu_start_o high at cycle 1 only, exu_valid_o high at cycle 9, stall_cnt_o=8.
REQ-035 SHALL cover: 4 single-cycle instructions with idu_valid_i and lsu_ready_i held high -> we_o high 4 consecutive cycles, exu_valid_o high 4 consecutive cycles.
REQ-036 SHALL cover: lsu_ready_i=0 for 5 cycles in VALID -> exu_valid_o held, we_o=0, exu_ready_o=0 throughout.
REQ-037 SHALL cover: flush_i at MC cycle 3 -> IDLE next cycle, exu_valid_o never asserts, stall_cnt_o=3.
REQ-038 SHALL cover: EXU_MULDIV_EN undefined, mc_op_i=1 accept -> exu_valid_o after 1 cycle, alu_start_o=0.
